mandel_slot_scheduler: RTL

//  Time-shares one two-phase mandel_iter core among NSLOTS in-flight pixel jobs.

---
 rtl/mandel_slot_scheduler.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mandel_slot_scheduler.sv
// Round-robin scheduler that time-shares one two-phase mandel_iter core among
// NSLOTS in-flight pixel jobs, holding per-slot c/z/iteration context.
module mandel_slot_scheduler #(
  parameter int unsigned BITS     = 16,
  parameter int unsigned NSLOTS   = 4,
  parameter int unsigned ITER_W   = 4,
  parameter int unsigned MAX_ITER = 15,
  parameter int unsigned TAG_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [BITS-1:0]   job_x0,
  input  logic [BITS-1:0]   job_y0,
  input  logic [TAG_W-1:0]  job_tag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [TAG_W-1:0]  res_tag,
  output logic [ITER_W-1:0] res_iter,
  output logic              res_escaped,
  output logic              core_phase,
  output logic [BITS-1:0]   core_x0,
  output logic [BITS-1:0]   core_y0,
  output logic [BITS-1:0]   core_x_in,
  output logic [BITS-1:0]   core_y_in,
  input  logic [BITS-1:0]   core_x_out,
  input  logic [BITS-1:0]   core_y_out,
  input  logic              core_escape,
  output logic              idle
);

  localparam int unsigned SVC_W = (NSLOTS > 2) ? $clog2(NSLOTS) : 1;
  localparam logic [ITER_W:0] MAX_CNT = (ITER_W+1)'(MAX_ITER);

  typedef enum logic [1:0] {
    SLOT_FREE = 2'd0,
    SLOT_BUSY = 2'd1,
    SLOT_DONE = 2'd2
  } slot_state_e;

  slot_state_e       st_q   [NSLOTS];
  slot_state_e       st_d   [NSLOTS];
  logic [BITS-1:0]   x0_q   [NSLOTS];
  logic [BITS-1:0]   x0_d   [NSLOTS];
  logic [BITS-1:0]   y0_q   [NSLOTS];
  logic [BITS-1:0]   y0_d   [NSLOTS];
  logic [BITS-1:0]   x_q    [NSLOTS];
  logic [BITS-1:0]   x_d    [NSLOTS];
  logic [BITS-1:0]   y_q    [NSLOTS];
  logic [BITS-1:0]   y_d    [NSLOTS];
  logic [TAG_W-1:0]  tag_q  [NSLOTS];
  logic [TAG_W-1:0]  tag_d  [NSLOTS];
  logic [ITER_W-1:0] iter_q [NSLOTS];
  logic [ITER_W-1:0] iter_d [NSLOTS];
  logic              esc_q  [NSLOTS];
  logic              esc_d  [NSLOTS];

  logic              phase_q, phase_d;
  logic [SVC_W-1:0]  svc_q, svc_d;
  logic              armed_q, armed_d;
  logic              res_valid_q, res_valid_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;
  logic [ITER_W-1:0] res_iter_q, res_iter_d;
  logic              res_esc_q, res_esc_d;

  logic              any_free, any_busy, any_done;
  logic [SVC_W-1:0]  free_idx, done_idx;
  logic              accept, retire;
  logic [ITER_W:0]   iter_inc;

  // Descending scan so the lowest-index match is the one left standing.
  always_comb begin
    any_free = 1'b0;
    any_busy = 1'b0;
    any_done = 1'b0;
    free_idx = '0;
    done_idx = '0;
    for (int unsigned i = NSLOTS; i > 0; i--) begin
      if (st_q[i-1] == SLOT_FREE) begin
        any_free = 1'b1;
        free_idx = SVC_W'(i-1);
      end
      if (st_q[i-1] == SLOT_DONE) begin
        any_done = 1'b1;
        done_idx = SVC_W'(i-1);
      end
      if (st_q[i-1] == SLOT_BUSY) begin
        any_busy = 1'b1;
      end
    end
  end

  assign accept   = job_valid && any_free;
  assign retire   = (!res_valid_q || res_ready) && any_done;
  assign iter_inc = {1'b0, iter_q[svc_q]} + (ITER_W+1)'(1);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      phase_q     <= 1'b0;
      svc_q       <= '0;
      armed_q     <= 1'b0;
      res_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NSLOTS; i++) begin
        st_q[i] <= SLOT_FREE;
      end
    end else begin
      phase_q     <= phase_d;
      svc_q       <= svc_d;
      armed_q     <= armed_d;
      res_valid_q <= res_valid_d;
      st_q        <= st_d;
    end
  end

  always_ff @(posedge clk) begin
    x0_q       <= x0_d;
    y0_q       <= y0_d;
    x_q        <= x_d;
    y_q        <= y_d;
    tag_q      <= tag_d;
    iter_q     <= iter_d;
    esc_q      <= esc_d;
    res_tag_q  <= res_tag_d;
    res_iter_q <= res_iter_d;
    res_esc_q  <= res_esc_d;
  end

  always_comb begin
    st_d        = st_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    x_d         = x_q;
    y_d         = y_q;
    tag_d       = tag_q;
    iter_d      = iter_q;
    esc_d       = esc_q;
    phase_d     = ~phase_q;
    svc_d       = phase_q ? svc_q + SVC_W'(1) : svc_q;
    armed_d     = phase_q ? 1'b0 : (st_q[svc_q] == SLOT_BUSY);
    res_valid_d = res_valid_q;
    res_tag_d   = res_tag_q;
    res_iter_d  = res_iter_q;
    res_esc_d   = res_esc_q;

    // The armed slot is BUSY, so it never collides with the accept or retire target.
    if (phase_q && armed_q) begin
      if (core_escape) begin
        st_d[svc_q]  = SLOT_DONE;
        esc_d[svc_q] = 1'b1;
      end else if (iter_inc == MAX_CNT) begin
        st_d[svc_q]   = SLOT_DONE;
        iter_d[svc_q] = MAX_CNT[ITER_W-1:0];
        esc_d[svc_q]  = 1'b0;
      end else begin
        iter_d[svc_q] = iter_inc[ITER_W-1:0];
        x_d[svc_q]    = core_x_out;
        y_d[svc_q]    = core_y_out;
      end
    end

    if (accept) begin
      st_d[free_idx]   = SLOT_BUSY;
      x0_d[free_idx]   = job_x0;
      y0_d[free_idx]   = job_y0;
      x_d[free_idx]    = job_x0;
      y_d[free_idx]    = job_y0;
      tag_d[free_idx]  = job_tag;
      iter_d[free_idx] = '0;
      esc_d[free_idx]  = 1'b0;
    end

    if (retire) begin
      res_valid_d    = 1'b1;
      res_tag_d      = tag_q[done_idx];
      res_iter_d     = iter_q[done_idx];
      res_esc_d      = esc_q[done_idx];
      st_d[done_idx] = SLOT_FREE;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_comb begin
    job_ready   = any_free;
    idle        = !any_busy && !any_done && !res_valid_q;
    res_valid   = res_valid_q;
    res_tag     = res_tag_q;
    res_iter    = res_iter_q;
    res_escaped = res_esc_q;
    core_phase  = phase_q;
    core_x0     = x0_q[svc_q];
    core_y0     = y0_q[svc_q];
    core_x_in   = x_q[svc_q];
    core_y_in   = y_q[svc_q];
  end

endmodule
